// File: rtl/xor_share_arbiter.sv
// xor_share_arbiter: round-robin arbiter sharing one registered XOR unit among NREQ requesters.
// Optional result parity (res_par, par_err_inj) is enabled by defining XOR_SHARE_ARBITER_PARITY_EN.
module xor_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W-1:0]      res_data,
    output logic [IDW-1:0]    res_id,
    output logic              busy,
`ifdef XOR_SHARE_ARBITER_PARITY_EN
    output logic              res_par,
    input  logic              par_err_inj,
`endif
    output logic [CNTW-1:0]   op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, OUT} state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_rr_ptr;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [IDW-1:0]  r_id;
    logic            r_res_valid;
    logic [W-1:0]    r_res_data;
    logic [IDW-1:0]  r_res_id;
    logic [CNTW-1:0] r_op_count;
    logic            w_found;
    logic [IDW-1:0]  w_win;
    logic [IDW:0]    w_sum;
    logic [IDW-1:0]  w_cand;
    logic [NREQ-1:0] w_grant;
    logic [W-1:0]    w_a;
    logic [W-1:0]    w_b;

    // Scan from the round-robin pointer upward, wrapping at NREQ; first valid wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_grant = '0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum  = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            w_cand = (w_sum >= (IDW+1)'(NREQ)) ? IDW'(w_sum - (IDW+1)'(NREQ)) : w_sum[IDW-1:0];
            if (!w_found && req_valid[w_cand]) begin
                w_found         = 1'b1;
                w_win           = w_cand;
                w_grant[w_cand] = 1'b1;
            end
        end
        w_a = req_a[w_win*W +: W];
        w_b = req_b[w_win*W +: W];
    end

    assign req_ready = (r_state == IDLE && !rst) ? w_grant : '0;
    assign busy      = (r_state != IDLE);
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;
    assign op_count  = r_op_count;

`ifdef XOR_SHARE_ARBITER_PARITY_EN
    logic r_res_par;
    assign res_par = r_res_par;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_res_par <= 1'b0;
        else if (r_state == EXEC)
            r_res_par <= (^(r_a ^ r_b)) ^ par_err_inj;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_id        <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_id    <= '0;
            r_op_count  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_a     <= w_a;
                        r_b     <= w_b;
                        r_id    <= w_win;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_res_data  <= r_a ^ r_b;
                    r_res_id    <= r_id;
                    r_res_valid <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_rr_ptr    <= (r_id == IDW'(NREQ-1)) ? '0 : r_id + 1'b1;
                        r_op_count  <= (r_op_count == '1) ? r_op_count : r_op_count + 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xor_share_arbiter.sv
// tb_xor_share_arbiter: directed tests of grant order, latency, backpressure, async reset and counter saturation.
// A second instance with CNTW=2 shares the stimulus to exercise op_count saturation.
module tb_xor_share_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready, s_req_ready;
    logic [31:0] req_a, req_b;
    logic        res_ready;
    logic        res_valid, s_res_valid;
    logic [7:0]  res_data, s_res_data;
    logic [1:0]  res_id, s_res_id;
    logic        busy, s_busy;
    logic [15:0] op_count;
    logic [1:0]  s_op_count;
`ifdef XOR_SHARE_ARBITER_PARITY_EN
    logic        par_err_inj, res_par, s_res_par;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xor_share_arbiter #(.NREQ(4), .W(8), .IDW(2), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .busy(busy),
`ifdef XOR_SHARE_ARBITER_PARITY_EN
        .res_par(res_par), .par_err_inj(par_err_inj),
`endif
        .op_count(op_count)
    );

    xor_share_arbiter #(.NREQ(4), .W(8), .IDW(2), .CNTW(2)) dut_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready),
        .req_a(req_a), .req_b(req_b), .res_valid(s_res_valid), .res_ready(res_ready),
        .res_data(s_res_data), .res_id(s_res_id), .busy(s_busy),
`ifdef XOR_SHARE_ARBITER_PARITY_EN
        .res_par(s_res_par), .par_err_inj(par_err_inj),
`endif
        .op_count(s_op_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        req_valid = 4'b0000;
        res_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 4'b1111;
        res_ready = 1'b1;
        req_a = '0;
        req_b = '0;
`ifdef XOR_SHARE_ARBITER_PARITY_EN
        par_err_inj = 1'b0;
`endif
        #2;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", res_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", op_count); end
        checks++; if (res_data !== 8'h00 || res_id !== 2'd0) begin errors++; $display("FAIL reset_data: got %h/%0d want 00/0", res_data, res_id); end
        apply_reset();
    endtask

    task automatic test_single;
        req_a[7:0] = 8'hA5;
        req_b[7:0] = 8'h3C;
        req_valid = 4'b0001;
        res_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
        tick();
        req_valid = 4'b0000;
        checks++; if (busy !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL single_exec: got busy=%b valid=%b want 1/0", busy, res_valid); end
        tick();
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_latency: got valid=%b want 1", res_valid); end
        checks++; if (res_data !== 8'h99 || res_id !== 2'd0) begin errors++; $display("FAIL single_data: got %h/%0d want 99/0", res_data, res_id); end
        tick();
        checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL single_count: got %0d want 1", op_count); end
        checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL single_done: got busy=%b valid=%b want 0/0", busy, res_valid); end
    endtask

    task automatic test_round_robin;
        logic [7:0] exp_rr [4];
        exp_rr = '{8'h11, 8'hDD, 8'hC3, 8'h4B};
        apply_reset();
        req_a = 32'h44332211;
        req_b = 32'h0FF0FF00;
        req_valid = 4'b1111;
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (req_ready !== (4'b0001 << (i % 4))) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", i, req_ready, 4'b0001 << (i % 4)); end
            tick();
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr_exec_ready%0d: got %b want 0000", i, req_ready); end
            tick();
            checks++; if (res_valid !== 1'b1 || res_id !== 2'(i % 4) || res_data !== exp_rr[i % 4]) begin errors++; $display("FAIL rr_result%0d: got v=%b id=%0d d=%h want 1/%0d/%h", i, res_valid, res_id, res_data, i % 4, exp_rr[i % 4]); end
            tick();
        end
        checks++; if (op_count !== 16'd5) begin errors++; $display("FAIL rr_count: got %0d want 5", op_count); end
    endtask

    task automatic test_backpressure;
        res_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
        tick();
        tick();
        req_a[15:8] = 8'h77;
        for (int i = 0; i < 5; i++) begin
            checks++; if (res_valid !== 1'b1 || res_data !== 8'hDD || res_id !== 2'd1) begin errors++; $display("FAIL bp_hold%0d: got v=%b d=%h id=%0d want 1/DD/1", i, res_valid, res_data, res_id); end
            checks++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL bp_stall%0d: got ready=%b busy=%b want 0000/1", i, req_ready, busy); end
            tick();
        end
        res_ready = 1'b1;
        tick();
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release: got v=%b busy=%b want 0/0", res_valid, busy); end
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_next_grant: got %b want 0100", req_ready); end
        checks++; if (op_count !== 16'd6) begin errors++; $display("FAIL bp_count: got %0d want 6", op_count); end
        req_a[15:8] = 8'h22;
    endtask

    task automatic test_pointer_skip;
        req_valid = 4'b1001;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL skip_grant3: got %b want 1000", req_ready); end
        tick();
        tick();
        checks++; if (res_id !== 2'd3 || res_data !== 8'h4B) begin errors++; $display("FAIL skip_result3: got id=%0d d=%h want 3/4B", res_id, res_data); end
        tick();
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL skip_grant0: got %b want 0001", req_ready); end
        tick();
        req_valid = 4'b0000;
        tick();
        checks++; if (res_id !== 2'd0 || res_data !== 8'h11) begin errors++; $display("FAIL skip_result0: got id=%0d d=%h want 0/11", res_id, res_data); end
        tick();
    endtask

    task automatic test_async_reset;
        res_ready = 1'b0;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        tick();
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL areset_pre: got valid=%b want 1", res_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL areset_drop: got v=%b busy=%b want 0/0", res_valid, busy); end
        checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL areset_count: got %0d want 0", op_count); end
        tick();
        rst = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL areset_quiet%0d: got v=%b busy=%b want 0/0", i, res_valid, busy); end
        end
    endtask

    task automatic test_saturation;
        int exp_sat [5];
        exp_sat = '{1, 2, 3, 3, 3};
        req_valid = 4'b0001;
        res_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
            tick();
            tick();
            checks++; if (s_op_count !== 2'(exp_sat[n])) begin errors++; $display("FAIL sat_count%0d: got %0d want %0d", n, s_op_count, exp_sat[n]); end
            checks++; if (op_count !== 16'(n + 1)) begin errors++; $display("FAIL wide_count%0d: got %0d want %0d", n, op_count, n + 1); end
        end
        req_valid = 4'b0000;
        tick();
    endtask

`ifdef XOR_SHARE_ARBITER_PARITY_EN
    task automatic test_parity;
        apply_reset();
        req_a[7:0] = 8'h01;
        req_b[7:0] = 8'h00;
        res_ready = 1'b1;
        par_err_inj = 1'b0;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        tick();
        checks++; if (res_par !== 1'b1 || res_data !== 8'h01) begin errors++; $display("FAIL par_normal: got p=%b d=%h want 1/01", res_par, res_data); end
        tick();
        par_err_inj = 1'b1;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        tick();
        par_err_inj = 1'b0;
        checks++; if (res_par !== 1'b0) begin errors++; $display("FAIL par_inject: got %b want 0", res_par); end
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_pointer_skip();
        test_async_reset();
        test_saturation();
`ifdef XOR_SHARE_ARBITER_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
